// File: rtl/jtag_dmi_mem_target_if.sv
// DMI request/response bundle between a debug-module initiator and a memory target.
// Handshake: a beat transfers on a rising clk edge where valid && ready are both high;
// the source holds valid and its payload stable until that edge, and ready never
// depends on valid.
interface jtag_dmi_mem_target_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
);
  logic              dmi_req_valid;
  logic              dmi_req_ready;
  logic [1:0]        dmi_op;
  logic [ADDR_W-1:0] dmi_addr;
  logic [DATA_W-1:0] dmi_wdata;
  logic              dmi_resp_valid;
  logic              dmi_resp_ready;
  logic [DATA_W-1:0] dmi_rdata;
  logic [1:0]        dmi_resp;

  modport master (
    output dmi_req_valid, dmi_op, dmi_addr, dmi_wdata, dmi_resp_ready,
    input  dmi_req_ready, dmi_resp_valid, dmi_rdata, dmi_resp
  );

  modport slave (
    input  dmi_req_valid, dmi_op, dmi_addr, dmi_wdata, dmi_resp_ready,
    output dmi_req_ready, dmi_resp_valid, dmi_rdata, dmi_resp
  );
endinterface

// File: rtl/jtag_dmi_mem_target.sv
// DMI target model: DEPTH-word register file with LATENCY wait states and a decoupled
// response channel. Optional macro JTAG_DMI_ERR_INJECT_EN adds err_inject_i.
module jtag_dmi_mem_target #(
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned LATENCY    = 2,
  parameter logic [31:0] RESET_DATA = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef JTAG_DMI_ERR_INJECT_EN
  input  logic                 err_inject_i,
`endif
  jtag_dmi_mem_target_if.slave dmi,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] OP_NOP       = 2'd0;
  localparam logic [1:0] OP_READ      = 2'd1;
  localparam logic [1:0] OP_WRITE     = 2'd2;
  localparam logic [1:0] RESP_SUCCESS = 2'd0;
  localparam logic [1:0] RESP_FAILED  = 2'd2;

  localparam int unsigned       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_W-1:0] RST_WORD = DATA_W'(RESET_DATA);
  localparam logic [7:0]        LAT_INIT = 8'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state;
  logic [7:0]        cnt;
  logic [1:0]        cap_op;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        resp_q;

  logic              accept;
  logic              enter_resp;
  logic [1:0]        src_op;
  logic [ADDR_W-1:0] src_addr;
  logic [DATA_W-1:0] src_wdata;
  logic              src_err;
  logic [IDX_W-1:0]  src_idx;
  logic              in_range;
  logic              dec_we;
  logic [DATA_W-1:0] dec_rdata;
  logic [1:0]        dec_resp;

  assign accept     = (state == S_IDLE) && dmi.dmi_req_valid;
  assign enter_resp = (accept && (LATENCY == 0)) || ((state == S_WAIT) && (cnt == 8'd1));

  // With zero wait states the decode happens on the accept edge itself, so it must
  // see the live request; otherwise it sees the captured copy.
  always_comb begin
    src_op    = cap_op;
    src_addr  = cap_addr;
    src_wdata = cap_wdata;
    if (state == S_IDLE) begin
      src_op    = dmi.dmi_op;
      src_addr  = dmi.dmi_addr;
      src_wdata = dmi.dmi_wdata;
    end
  end

`ifdef JTAG_DMI_ERR_INJECT_EN
  logic cap_err;
  assign src_err = (state == S_IDLE) ? err_inject_i : cap_err;
`else
  assign src_err = 1'b0;
`endif

  assign in_range = 32'(src_addr) < 32'(DEPTH);
  assign src_idx  = src_addr[IDX_W-1:0];

  always_comb begin
    dec_we    = 1'b0;
    dec_rdata = '0;
    dec_resp  = RESP_SUCCESS;
    if (src_err || !in_range) begin
      dec_resp = RESP_FAILED;
    end else begin
      case (src_op)
        OP_READ:  dec_rdata = mem[src_idx];
        OP_WRITE: dec_we    = 1'b1;
        OP_NOP:   dec_resp  = RESP_SUCCESS;
        default:  dec_resp  = RESP_FAILED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cap_op    <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
`ifdef JTAG_DMI_ERR_INJECT_EN
      cap_err   <= 1'b0;
`endif
      rdata_q   <= '0;
      resp_q    <= RESP_SUCCESS;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= RST_WORD;
    end else begin
      if (enter_resp) begin
        if (dec_we) mem[src_idx] <= src_wdata;
        rdata_q <= dec_rdata;
        resp_q  <= dec_resp;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            cap_op    <= dmi.dmi_op;
            cap_addr  <= dmi.dmi_addr;
            cap_wdata <= dmi.dmi_wdata;
`ifdef JTAG_DMI_ERR_INJECT_EN
            cap_err   <= err_inject_i;
`endif
            cnt       <= LAT_INIT;
            state     <= (LATENCY == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 8'd1) state <= S_RESP;
          else             cnt   <= cnt - 8'd1;
        end
        S_RESP: begin
          if (dmi.dmi_resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dmi.dmi_req_ready  = (state == S_IDLE);
  assign dmi.dmi_resp_valid = (state == S_RESP);
  assign dmi.dmi_rdata      = rdata_q;
  assign dmi.dmi_resp       = resp_q;
  assign busy               = (state != S_IDLE);
  assign dbg_state          = state;

endmodule
